// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter merging ALU and load writebacks onto one registered
// register-file write port.
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ack,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ack,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] DW,
  output logic              last_grant
);
  logic              take;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  always_comb begin
    alu_ack = reset & alu_req & (~mem_req | last_grant);
    mem_ack = reset & mem_req & (~alu_req | ~last_grant);
    take    = alu_ack | mem_ack;
    addr    = mem_ack ? mem_addr : alu_addr;
    data    = mem_ack ? mem_data : alu_data;
  end
  // Register 0 is hardwired: its transfers are accepted but never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite   <= 1'b0;
      WR         <= '0;
      DW         <= '0;
      last_grant <= 1'b1;
    end else begin
      RegWrite <= take && addr != '0;
      if (take) last_grant <= mem_ack;
      if (take && addr != '0) begin
        WR <= addr;
        DW <= data;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed and random checks of reg_wb_arbiter against a
// transaction-level model of the round-robin writeback port.
module tb_reg_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_req = 1'b0, mem_req = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ack, mem_ack, RegWrite, last_grant;
  logic [4:0]  WR;
  logic [31:0] DW;
  int tests = 0, fails = 0;
  int gnt;
  int writes;
  int wait_a, wait_m;
  logic        m_lg, m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_dw;

  reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .RegWrite(RegWrite), .WR(WR), .DW(DW), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lg = 1'b1; m_rw = 1'b0; m_wr = '0; m_dw = '0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(m_rw));
    chk({tag, ".WR"}, 32'(WR), 32'(m_wr));
    chk({tag, ".DW"}, DW, m_dw);
    chk({tag, ".last_grant"}, 32'(last_grant), 32'(m_lg));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic [4:0]  a;
    logic [31:0] d;
    #1;
    if (alu_req && mem_req) gnt = m_lg ? 0 : 1;
    else if (alu_req) gnt = 0;
    else if (mem_req) gnt = 1;
    else gnt = -1;
    chk({tag, ".alu_ack"}, 32'(alu_ack), 32'(gnt == 0));
    chk({tag, ".mem_ack"}, 32'(mem_ack), 32'(gnt == 1));
    a = (gnt == 1) ? mem_addr : alu_addr;
    d = (gnt == 1) ? mem_data : alu_data;
    @(posedge clk);
    m_rw = 1'b0;
    if (gnt >= 0) begin
      m_lg = (gnt == 1);
      if (a != 0) begin
        m_rw = 1'b1; m_wr = a; m_dw = d;
      end
    end
    #1;
    chk_regs(tag);
    if (RegWrite) writes++;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    chk_regs(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk_regs("rst");
    alu_req = 1'b1; mem_req = 1'b1;
    #1;
    chk("rst.alu_ack", 32'(alu_ack), 32'd0);
    chk("rst.mem_ack", 32'(mem_ack), 32'd0);
    alu_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    alu_req = 1'b1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    cycle("single");
    alu_req = 1'b0;
    cycle("single_idle");

    do_reset("rst2");
    alu_req = 1'b1; alu_addr = 3; alu_data = 32'h33;
    mem_req = 1'b1; mem_addr = 4; mem_data = 32'h44;
    cycle("tie1");
    chk("tie1.gnt", 32'(gnt), 32'd0);
    alu_req = 1'b0;
    cycle("tie2");
    chk("tie2.gnt", 32'(gnt), 32'd1);
    mem_req = 1'b0;

    writes = 0;
    alu_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("alt");
      if (gnt == 0) begin alu_addr = 5'(i + 1); alu_data = 32'hA000 + i; end
      if (gnt == 1) begin mem_addr = 5'(i + 10); mem_data = 32'hB000 + i; end
    end
    chk("alt.writes", 32'(writes), 32'd6);
    alu_req = 1'b0; mem_req = 1'b0;

    mem_req = 1'b1; mem_addr = 0; mem_data = 32'h12345678;
    cycle("zero");
    mem_req = 1'b0;

    alu_req = 1'b1; alu_addr = 7; alu_data = 32'h77;
    cycle("pre_rst");
    alu_req = 1'b0;
    do_reset("midrst");

    alu_req = 1'b1; alu_addr = 9; alu_data = 32'h99;
    cycle("set_lg0");
    alu_addr = 2; alu_data = 32'h22;
    mem_req = 1'b1; mem_addr = 12; mem_data = 32'hC0C0;
    cycle("drop");
    chk("drop.gnt", 32'(gnt), 32'd1);
    alu_req = 1'b0; mem_req = 1'b0;
    cycle("drop_idle");

    wait_a = 0; wait_m = 0;
    for (int i = 0; i < 300; i++) begin
      if (!alu_req && $urandom_range(1, 0) == 1) begin
        alu_req = 1'b1; alu_addr = 5'($urandom); alu_data = $urandom; wait_a = 0;
      end
      if (!mem_req && $urandom_range(1, 0) == 1) begin
        mem_req = 1'b1; mem_addr = 5'($urandom); mem_data = $urandom; wait_m = 0;
      end
      cycle("rand");
      if (gnt == 0) begin
        chk("rand.alu_wait", 32'(wait_a < 2), 32'd1);
        alu_req = 1'b0;
      end else if (alu_req) begin
        wait_a++;
        if ($urandom_range(9, 0) == 0) alu_req = 1'b0;
      end
      if (gnt == 1) begin
        chk("rand.mem_wait", 32'(wait_m < 2), 32'd1);
        mem_req = 1'b0;
      end else if (mem_req) begin
        wait_m++;
        if ($urandom_range(9, 0) == 0) mem_req = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of write data.
REQ-002 Parameter ADDR_W, default 5, width of register address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 alu_req  input  1  ALU writeback request (requester 0).
REQ-006 alu_addr  input  ADDR_W  ALU destination register.
REQ-007 alu_data  input  DATA_W  ALU writeback data.
REQ-008 alu_ack  output  1  ALU request accepted this cycle.
REQ-009 mem_req  input  1  load writeback request (requester 1).
REQ-010 mem_addr  input  ADDR_W  load destination register.
REQ-011 mem_data  input  DATA_W  load writeback data.
REQ-012 mem_ack  output  1  load request accepted this cycle.
REQ-013 RegWrite  output  1  registered write enable to register file.
REQ-014 WR  output  ADDR_W  registered write address to register file.
REQ-015 DW  output  DATA_W  registered write data to register file.
REQ-016 last_grant  output  1  round-robin pointer; 0 = ALU served last, 1 = load served last.

Function
REQ-017 Requester x holds req, addr, data stable from assertion until the cycle its ack is high; the transfer completes on the rising edge where req and ack are both high.
REQ-018 ack outputs are combinational from req inputs and last_grant; at most one ack high per cycle.
REQ-019 Only alu_req high: alu_ack=1. Only mem_req high: mem_ack=1. Neither high: both acks 0.
REQ-020 Both high: grant the requester not named by last_grant (last_grant=0 -> mem_ack=1; last_grant=1 -> alu_ack=1).
REQ-021 last_grant updates on every accepted transfer to the granted requester index; holds otherwise.
REQ-022 Latency: on the edge accepting a transfer, RegWrite<=1, WR<=granted addr, DW<=granted data; register file commits on the following edge.
REQ-023 No transfer accepted in a cycle: RegWrite<=0; WR and DW hold previous values.
REQ-024 A transfer with addr=0 is acknowledged and updates last_grant, but RegWrite<=0 (register 0 writes discarded); WR/DW hold.
REQ-025 Back-to-back transfers: one accepted per cycle, no idle bubble; with both requesting continuously, grants alternate ALU/load every cycle.
REQ-026 Starvation bound: a held request is acknowledged within 2 cycles of assertion.
REQ-027 Deassertion of req before ack: no transfer, no state change.

Reset
REQ-028 reset low asynchronously forces RegWrite=0, WR=0, DW=0, last_grant=1 (ALU wins first tie); acks remain combinational but are forced 0 while reset is low.
REQ-029 Reset asserted mid-transfer: pending RegWrite cleared immediately; transfer lost; requesters re-present after reset release.
REQ-030 First rising edge after reset deasserts operates normally; no synchronisation cycle.

Verification
REQ-031 Reset, alu_req=1 addr=5 data=0xDEADBEEF one cycle -> alu_ack=1 same cycle; next cycle RegWrite=1 WR=5 DW=0xDEADBEEF; cycle after RegWrite=0.
REQ-032 After reset, alu_req and mem_req both high with addrs 3/4 -> alu_ack first; next cycle mem_ack; WR sequence 3,4; last_grant 0 then 1.
REQ-033 Both requesters held 6 cycles with distinct data -> strict alternation, 6 consecutive RegWrite=1 cycles, no lost or duplicated write.
REQ-034 mem_req addr=0 data=0x12345678 -> mem_ack=1; RegWrite stays 0; WR/DW unchanged; last_grant=1.
REQ-035 reset pulsed low while RegWrite=1 -> RegWrite, WR, DW 0 before next edge; last_grant=1.
REQ-036 alu_req pulsed one cycle during mem grant then dropped -> no ALU write appears; mem write completes normally.
